// File: rtl/ahb_lite_slave_fabric.sv
// AHB-Lite decoder and response multiplexer for SLV_CNT slaves with a built-in ERROR default slave.
// Define AHB_FABRIC_TIMEOUT_EN to add the hung-slave timeout counter and the timeout_o port.
module ahb_lite_slave_fabric #(
  parameter int                      SLV_CNT        = 4,
  parameter int                      DATA_W         = 32,
  parameter logic [SLV_CNT*32-1:0]   SLV_BASE       = {SLV_CNT{32'h0}},
  parameter logic [SLV_CNT*32-1:0]   SLV_MASK       = {SLV_CNT{32'hFFFF_0000}},
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 haddr,
  input  logic [1:0]                  htrans,
  output logic [SLV_CNT-1:0]          hsel_o,
  input  logic [SLV_CNT*DATA_W-1:0]   s_hrdata,
  input  logic [SLV_CNT-1:0]          s_hreadyout,
  input  logic [SLV_CNT-1:0]          s_hresp,
  output logic [DATA_W-1:0]           hrdata,
  output logic                        hready,
  output logic                        hresp
`ifdef AHB_FABRIC_TIMEOUT_EN
  ,
  output logic                        timeout_o
`endif
);

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [SLV_CNT-1:0] match;
  logic [SLV_CNT-1:0] dp_sel_q, dp_sel_d;
  logic               dp_def_q, dp_def_d;
  ds_state_t          state_q, state_d;
  logic [DATA_W-1:0]  sel_rdata;
  logic               sel_ready;
  logic               sel_resp;
  logic               dp_active;
  logic               slave_stall;
  logic               to_hit;

  generate
    for (genvar gi = 0; gi < SLV_CNT; gi++) begin : g_dec
      assign match[gi] = (haddr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
    end
  endgenerate

  // Lowest index wins on overlap: keep only the least-significant set bit.
  assign hsel_o = match & (~match + SLV_CNT'(1));

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_resp  = 1'b0;
    for (int i = 0; i < SLV_CNT; i++) begin
      if (dp_sel_q[i]) begin
        sel_rdata = sel_rdata | s_hrdata[DATA_W*i +: DATA_W];
        sel_ready = sel_ready | s_hreadyout[i];
        sel_resp  = sel_resp  | s_hresp[i];
      end
    end
  end

  assign dp_active   = |dp_sel_q;
  assign slave_stall = dp_active & ~sel_ready;

  always_comb begin
    if (dp_active) begin
      hrdata = sel_rdata;
      hready = sel_ready;
      hresp  = sel_resp;
    end else begin
      hrdata = '0;
      hready = ~(dp_def_q && (state_q == DS_ERR1));
      hresp  = dp_def_q && (state_q != DS_IDLE);
    end
  end

  always_comb begin
    dp_sel_d = dp_sel_q;
    dp_def_d = dp_def_q;
    state_d  = state_q;
    if (hready) begin
      dp_sel_d = htrans[1] ? hsel_o : '0;
      dp_def_d = htrans[1] & ~|hsel_o;
    end
    case (state_q)
      DS_ERR1: state_d = DS_ERR2;
      default: state_d = (hready && dp_def_d) ? DS_ERR1 : DS_IDLE;
    endcase
    // A timed-out slave is dropped and the default slave answers with ERROR instead.
    if (to_hit) begin
      dp_sel_d = '0;
      dp_def_d = 1'b1;
      state_d  = DS_ERR1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sel_q <= '0;
      dp_def_q <= 1'b0;
      state_q  <= DS_IDLE;
    end else begin
      dp_sel_q <= dp_sel_d;
      dp_def_q <= dp_def_d;
      state_q  <= state_d;
    end
  end

`ifdef AHB_FABRIC_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;

  assign to_hit = slave_stall && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (hready || to_hit) begin
      to_cnt_d = '0;
    end else if (slave_stall) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
    timeout_d = timeout_q | to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_slave_fabric.sv
// Scoreboard bench for ahb_lite_slave_fabric: directed scenarios then randomized traffic,
// every data-phase cycle checked against a transaction-level model of the bus.
module tb_ahb_lite_slave_fabric;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [N*32-1:0] BASE = {32'h4000_0000, 32'hFFF0_0000, 32'hFFDF_0000, 32'hFFFF_0000};
  localparam logic [N*32-1:0] MASK = {32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000};
`ifdef AHB_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [1:0] K_IDLE = 2'd0, K_UNM = 2'd1, K_SLV = 2'd2;
  localparam int M_FIX = 0, M_RAND = 1, M_WAIT = 2, M_STUCK = 3;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] slv;
  } rec_t;

  logic              clk;
  logic              rst_n;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic [N-1:0]      hsel_o;
  logic [N*DW-1:0]   s_hrdata;
  logic [N-1:0]      s_hreadyout;
  logic [N-1:0]      s_hresp;
  logic [DW-1:0]     hrdata;
  logic              hready;
  logic              hresp;
`ifdef AHB_FABRIC_TIMEOUT_EN
  logic              timeout_o;
`endif

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mode;
  int   scyc;
  int   txn = 0;

  ahb_lite_slave_fabric #(
    .SLV_CNT(N), .DATA_W(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .haddr(haddr), .htrans(htrans), .hsel_o(hsel_o),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
`ifdef AHB_FABRIC_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: first region (lowest index) whose masked address equals its base.
  function automatic logic [N-1:0] exp_sel(input logic [31:0] a);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (s == '0 && ((a & MASK[32*i +: 32]) == BASE[32*i +: 32])) s[i] = 1'b1;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive_slaves();
    logic [31:0] r;
    for (int i = 0; i < N; i++) begin
      s_hreadyout[i] = 1'b1;
      s_hresp[i]     = 1'b0;
      s_hrdata[DW*i +: DW] = 32'hA5A5_0000 | 32'(i);
      if (mode == M_RAND) begin
        r = $urandom();
        r[3:0] = 4'(i);
        s_hrdata[DW*i +: DW] = r;
        s_hreadyout[i] = ($urandom_range(3) != 0);
        s_hresp[i]     = ($urandom_range(7) == 0);
      end else if (mode == M_WAIT && i == 1) begin
        s_hreadyout[i] = !(scyc >= 1 && scyc <= 3);
      end else if (mode == M_STUCK && i == 1) begin
        s_hreadyout[i] = (scyc == 9);
      end
    end
    scyc++;
  endtask

  // Present one address phase, holding it until accepted, and queue its expected data phase.
  task automatic issue(input logic [31:0] a, input logic [1:0] t);
    logic [N-1:0] es;
    rec_t r;
    es = exp_sel(a);
    for (int n = 0; n < 64; n++) begin
      @(posedge clk); #1;
      drive_slaves();
      haddr  = a;
      htrans = t;
      @(negedge clk); #1;
      chk("hsel", 64'(hsel_o), 64'(es));
      if (hready === 1'b1) begin
        r.kind = !t[1] ? K_IDLE : ((es == '0) ? K_UNM : K_SLV);
        r.slv  = 2'd0;
        for (int i = 0; i < N; i++) if (es[i]) r.slv = 2'(i);
        exp_q.push_back(r);
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL accept_timeout addr=%h got=stalled exp=accepted within 64 cycles", a);
  endtask

  task automatic do_reset();
    rec_t r;
    htrans = T_IDLE;
    haddr  = '0;
    rst_n  = 1'b0;
    #1;
    chk("rst_hready", 64'(hready), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
`ifdef AHB_FABRIC_TIMEOUT_EN
    chk("rst_timeout", 64'(timeout_o), 64'd0);
`endif
    exp_q.delete();
    r.kind = K_IDLE;
    r.slv  = 2'd0;
    exp_q.push_back(r);
    @(negedge clk); #3;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle belongs to the oldest outstanding data phase; it ends when hready is high.
  int   ph = 0;
  int   stalls = 0;
  bit   to_seen = 1'b0;
  always @(negedge clk) begin
    rec_t        r;
    logic        er, ep;
    logic [DW-1:0] ed;
    bit          err_phase;
    if (!rst_n) begin
      ph = 0;
      stalls = 0;
      to_seen = 1'b0;
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard got=no expected entry exp=one entry per data phase");
    end else begin
      r  = exp_q[0];
      er = 1'b1;
      ep = 1'b0;
      ed = '0;
      err_phase = (r.kind == K_UNM) || (r.kind == K_SLV && TO_EN && stalls >= TO);
      if (err_phase) begin
        er = (ph == 1);
        ep = 1'b1;
      end else if (r.kind == K_SLV) begin
        er = s_hreadyout[r.slv];
        ep = s_hresp[r.slv];
        ed = s_hrdata[DW*r.slv +: DW];
      end
      checks++;
      if ({hready, hresp, hrdata} !== {er, ep, ed}) begin
        errors++;
        $display("FAIL resp kind=%0d slv=%0d got ready=%b resp=%b data=%h exp ready=%b resp=%b data=%h",
                 r.kind, r.slv, hready, hresp, hrdata, er, ep, ed);
      end
`ifdef AHB_FABRIC_TIMEOUT_EN
      checks++;
      if (timeout_o !== to_seen) begin
        errors++;
        $display("FAIL timeout_o got=%b exp=%b", timeout_o, to_seen);
      end
`endif
      if (er) begin
        $display("txn %0d kind=%0d slv=%0d hrdata=%h hresp=%b", txn, r.kind, r.slv, hrdata, hresp);
        txn++;
        void'(exp_q.pop_front());
        ph = 0;
        stalls = 0;
      end else if (err_phase) begin
        ph++;
      end else begin
        stalls++;
        if (TO_EN && stalls == TO) to_seen = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no finish exp=finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    rst_n  = 1'b1;
    haddr  = '0;
    htrans = T_IDLE;
    mode   = M_FIX;
    scyc   = 0;
    drive_slaves();
    #2;
    do_reset();

    issue(32'hFFDF_0004, T_NSEQ);
    issue(32'hFFDF_0008, T_IDLE);

    mode = M_WAIT; scyc = 0;
    issue(32'hFFDF_0010, T_NSEQ);
    issue(32'h0000_0000, T_IDLE);
    mode = M_FIX;

    issue(32'h1000_0000, T_NSEQ);
    issue(32'h1000_0000, T_IDLE);
    issue(32'h0000_0000, T_IDLE);

    issue(32'hFFFF_0020, T_NSEQ);
    issue(32'hFFF1_0000, T_NSEQ);
    issue(32'h1000_0004, T_NSEQ);
    issue(32'h2000_0000, T_IDLE);
    issue(32'h3000_0000, T_BUSY);
    issue(32'h0000_0000, T_IDLE);

    issue(32'hFFFF_0010, T_NSEQ);
    issue(32'h0000_0000, T_IDLE);

`ifdef AHB_FABRIC_TIMEOUT_EN
    mode = M_STUCK; scyc = 0;
    issue(32'hFFDF_0000, T_NSEQ);
    issue(32'h0000_0000, T_IDLE);
    mode = M_FIX;
    issue(32'hFFDF_0000, T_NSEQ);
    issue(32'h0000_0000, T_IDLE);
`endif

    mode = M_WAIT; scyc = 0;
    issue(32'hFFDF_0000, T_NSEQ);
    @(posedge clk); #1;
    drive_slaves();
    haddr  = '0;
    htrans = T_IDLE;
    @(negedge clk); #3;
    do_reset();
    mode = M_FIX;
    issue(32'hFFDF_0000, T_NSEQ);
    issue(32'h0000_0000, T_IDLE);

    mode = M_RAND;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(5))
        0:       a = 32'hFFFF_0000;
        1:       a = 32'hFFDF_0000;
        2:       a = 32'hFFF4_0000;
        3:       a = 32'h4000_0000;
        4:       a = 32'h1000_0000;
        default: a = $urandom();
      endcase
      a[15:0] = 16'($urandom());
      a[1:0]  = 2'b00;
      t = 2'($urandom_range(3));
      if ($urandom_range(3) != 0) t[1] = 1'b1;
      issue(a, t);
    end
    mode = M_FIX;
    issue(32'h0000_0000, T_IDLE);
    issue(32'h0000_0000, T_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
